// File: rtl/branch_predict_table.sv
// Bimodal branch predictor: ENTRIES saturating counters indexed by PC.
// IF gets a combinational prediction. EXE resolves conditional branches
// from the comparator flags, trains the table and keeps statistics.
module branch_predict_table #(
   parameter int ENTRIES    = 16,
   parameter int PC_W       = 32,
   parameter int CTR_W      = 2,
   parameter int INIT_STATE = (1 << (CTR_W - 1)) - 1,
   parameter int STAT_W     = 16,
   parameter int BITS       = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clr_i,
   input  logic [PC_W-1:0]   if_pc_i,
   output logic [CTR_W-1:0]  pred_state_o,
   output logic              pred_taken_o,
   input  logic              ex_valid_i,
   input  logic [PC_W-1:0]   ex_pc_i,
   input  logic [CTR_W-1:0]  ex_pred_state_i,
   input  logic [BITS-1:0]   cmp_type_i,
   input  logic [BITS-1:0]   cmp_flag_i,
   output logic              is_cond_o,
   output logic              act_taken_o,
   output logic              mispredict_o,
   output logic [STAT_W-1:0] br_cnt_o,
   output logic [STAT_W-1:0] miss_cnt_o
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam logic [CTR_W-1:0] INIT_C = CTR_W'(INIT_STATE);

   localparam logic [BITS-1:0] F_EQ = BITS'(4'b0001);
   localparam logic [BITS-1:0] F_G  = BITS'(4'b0010);
   localparam logic [BITS-1:0] F_L  = BITS'(4'b0011);

   localparam logic [BITS-1:0] T_BEQ  = BITS'(4'b1001);
   localparam logic [BITS-1:0] T_BG   = BITS'(4'b1010);
   localparam logic [BITS-1:0] T_BL   = BITS'(4'b1011);
   localparam logic [BITS-1:0] T_BNE  = BITS'(4'b1100);
   localparam logic [BITS-1:0] T_BGE  = BITS'(4'b0001);
   localparam logic [BITS-1:0] T_BLTU = BITS'(4'b0010);

   logic [ENTRIES-1:0][CTR_W-1:0] ctr_q, ctr_d;
   logic [STAT_W-1:0]             br_q, br_d, miss_q, miss_d;
   logic                          is_cond_q, is_cond_d;
   logic                          act_q, act_d;
   logic                          mis_q, mis_d;

   logic [IDX_W-1:0] if_idx, ex_idx;
   logic             typ_cond, taken, cond, pred;
   logic [CTR_W-1:0] cur, nxt;
   logic             unused_bits;

   assign if_idx = if_pc_i[IDX_W+1:2];
   assign ex_idx = ex_pc_i[IDX_W+1:2];
   // Only the index bits and the carried MSB matter; fold the rest away.
   assign unused_bits = ^{if_pc_i, ex_pc_i, ex_pred_state_i};

   // Fetch read: current table contents, no bypass of a same-cycle write.
   assign pred_state_o = ctr_q[if_idx];
   assign pred_taken_o = pred_state_o[CTR_W-1];

   // Decode branch type and resolve direction from comparator flags.
   always_comb begin
      typ_cond = 1'b0;
      taken    = 1'b0;
      case (cmp_type_i)
         T_BEQ:  begin typ_cond = 1'b1; taken = (cmp_flag_i == F_EQ); end
         T_BG:   begin typ_cond = 1'b1; taken = (cmp_flag_i == F_G); end
         T_BL:   begin typ_cond = 1'b1; taken = (cmp_flag_i == F_L); end
         T_BNE:  begin typ_cond = 1'b1; taken = (cmp_flag_i == F_G) || (cmp_flag_i == F_L); end
         T_BGE:  begin typ_cond = 1'b1; taken = (cmp_flag_i == F_EQ) || (cmp_flag_i == F_G); end
         T_BLTU: begin typ_cond = 1'b1; taken = (cmp_flag_i == F_L); end
         default: ;
      endcase
   end

   assign cond = ex_valid_i && typ_cond;
   // The prediction judged is the one carried from fetch, not the table now.
   assign pred = ex_pred_state_i[CTR_W-1];
   // Training starts from the live table entry.
   assign cur  = ctr_q[ex_idx];

   // Saturating counter step toward the resolved direction.
   always_comb begin
      nxt = cur;
      if (taken) begin
         if (cur != {CTR_W{1'b1}}) nxt = cur + CTR_W'(1);
      end else begin
         if (cur != '0) nxt = cur - CTR_W'(1);
      end
   end

   // Next state for table, statistics and result flags; clear wins.
   always_comb begin
      ctr_d     = ctr_q;
      br_d      = br_q;
      miss_d    = miss_q;
      is_cond_d = cond;
      act_d     = cond && taken;
      mis_d     = cond && (taken != pred);
      if (clr_i) begin
         ctr_d     = {ENTRIES{INIT_C}};
         br_d      = '0;
         miss_d    = '0;
         is_cond_d = 1'b0;
         act_d     = 1'b0;
         mis_d     = 1'b0;
      end else if (cond) begin
         ctr_d[ex_idx] = nxt;
         if (br_q != {STAT_W{1'b1}}) br_d = br_q + STAT_W'(1);
         if ((taken != pred) && (miss_q != {STAT_W{1'b1}})) miss_d = miss_q + STAT_W'(1);
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ctr_q     <= {ENTRIES{INIT_C}};
         br_q      <= '0;
         miss_q    <= '0;
         is_cond_q <= 1'b0;
         act_q     <= 1'b0;
         mis_q     <= 1'b0;
      end else begin
         ctr_q     <= ctr_d;
         br_q      <= br_d;
         miss_q    <= miss_d;
         is_cond_q <= is_cond_d;
         act_q     <= act_d;
         mis_q     <= mis_d;
      end
   end

   assign is_cond_o    = is_cond_q;
   assign act_taken_o  = act_q;
   assign mispredict_o = mis_q;
   assign br_cnt_o     = br_q;
   assign miss_cnt_o   = miss_q;

endmodule

// File: tb/tb_branch_predict_table.sv
// Directed bench for branch_predict_table. Stimulus pushes hand-computed
// expectations into a scoreboard; a monitor checks them after each edge.
module tb_branch_predict_table;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr = 1'b0;
   logic [31:0] if_pc = '0;
   logic        ex_valid = 1'b0;
   logic [31:0] ex_pc = '0;
   logic [1:0]  ex_pst = '0;
   logic [3:0]  cmp_type = '0;
   logic [3:0]  cmp_flag = '0;

   logic [1:0]  pst;
   logic        ptk, ic, at, mp;
   logic [15:0] br, ms;

   logic [1:0]  pst2;
   logic        ptk2, ic2, at2, mp2;
   logic [1:0]  br2, ms2;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      logic        ic, at, mp;
      logic [15:0] br, ms;
      logic [1:0]  ps;
      logic [1:0]  br2, ms2;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   branch_predict_table dut (
      .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .if_pc_i(if_pc),
      .pred_state_o(pst), .pred_taken_o(ptk), .ex_valid_i(ex_valid),
      .ex_pc_i(ex_pc), .ex_pred_state_i(ex_pst), .cmp_type_i(cmp_type),
      .cmp_flag_i(cmp_flag), .is_cond_o(ic), .act_taken_o(at),
      .mispredict_o(mp), .br_cnt_o(br), .miss_cnt_o(ms)
   );

   // Narrow-statistics copy to exercise counter saturation.
   branch_predict_table #(.STAT_W(2)) dut2 (
      .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .if_pc_i(if_pc),
      .pred_state_o(pst2), .pred_taken_o(ptk2), .ex_valid_i(ex_valid),
      .ex_pc_i(ex_pc), .ex_pred_state_i(ex_pst), .cmp_type_i(cmp_type),
      .cmp_flag_i(cmp_flag), .is_cond_o(ic2), .act_taken_o(at2),
      .mispredict_o(mp2), .br_cnt_o(br2), .miss_cnt_o(ms2)
   );

   task automatic chk(input string name, input int got, input int want);
      n_chk++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   function automatic logic [1:0] sat2(input logic [15:0] v);
      return (v > 16'd3) ? 2'd3 : v[1:0];
   endfunction

   // Drive one EXE/IF cycle and queue the outputs expected after the edge.
   task automatic vec(input logic c, input logic v, input logic [31:0] pc,
                      input logic [1:0] ps_in, input logic [3:0] typ,
                      input logic [3:0] flg, input logic [31:0] ifp,
                      input logic eic, input logic eat, input logic emp,
                      input logic [15:0] ebr, input logic [15:0] ems,
                      input logic [1:0] eps);
      exp_t e;
      @(negedge clk);
      clr = c; ex_valid = v; ex_pc = pc; ex_pst = ps_in;
      cmp_type = typ; cmp_flag = flg; if_pc = ifp;
      e.ic = eic; e.at = eat; e.mp = emp; e.br = ebr; e.ms = ems; e.ps = eps;
      e.br2 = sat2(ebr); e.ms2 = sat2(ems);
      sb.push_back(e);
   endtask

   // Monitor: compare registered outputs and post-edge prediction.
   always @(posedge clk) begin
      exp_t e;
      #2;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("is_cond", int'(ic), int'(e.ic));
         chk("act_taken", int'(at), int'(e.at));
         chk("mispredict", int'(mp), int'(e.mp));
         chk("br_cnt", int'(br), int'(e.br));
         chk("miss_cnt", int'(ms), int'(e.ms));
         chk("pred_state", int'(pst), int'(e.ps));
         chk("pred_taken", int'(ptk), int'(e.ps[1]));
         chk("br_cnt_w2", int'(br2), int'(e.br2));
         chk("miss_cnt_w2", int'(ms2), int'(e.ms2));
      end
   end

   initial begin
      int budget;
      if_pc = 32'h40;
      repeat (2) @(negedge clk);
      chk("reset_pred", int'(pst), 1);
      chk("reset_br", int'(br), 0);
      rst_n = 1'b1;
      //   clr v  ex_pc   pst   type     flag     if_pc    ic at mp br ms ps
      vec(0, 0, 32'h40, 2'b00, 4'b0000, 4'b0000, 32'h40,  0, 0, 0, 0, 0, 2'b01);
      // BEQ taken at 0x40 with weak-not-taken carried state
      vec(0, 1, 32'h40, 2'b01, 4'b1001, 4'b0001, 32'h40,  1, 1, 1, 1, 1, 2'b10);
      // BLTU taken x5 at 0x44: saturate high
      vec(0, 1, 32'h44, 2'b01, 4'b0010, 4'b0011, 32'h44,  1, 1, 1, 2, 2, 2'b10);
      vec(0, 1, 32'h44, 2'b10, 4'b0010, 4'b0011, 32'h44,  1, 1, 0, 3, 2, 2'b11);
      vec(0, 1, 32'h44, 2'b11, 4'b0010, 4'b0011, 32'h44,  1, 1, 0, 4, 2, 2'b11);
      vec(0, 1, 32'h44, 2'b11, 4'b0010, 4'b0011, 32'h44,  1, 1, 0, 5, 2, 2'b11);
      vec(0, 1, 32'h44, 2'b11, 4'b0010, 4'b0011, 32'h44,  1, 1, 0, 6, 2, 2'b11);
      // BLTU not taken x5: saturate low
      vec(0, 1, 32'h44, 2'b11, 4'b0010, 4'b0001, 32'h44,  1, 0, 1, 7, 3, 2'b10);
      vec(0, 1, 32'h44, 2'b10, 4'b0010, 4'b0001, 32'h44,  1, 0, 1, 8, 4, 2'b01);
      vec(0, 1, 32'h44, 2'b01, 4'b0010, 4'b0001, 32'h44,  1, 0, 0, 9, 4, 2'b00);
      vec(0, 1, 32'h44, 2'b00, 4'b0010, 4'b0001, 32'h44,  1, 0, 0, 10, 4, 2'b00);
      vec(0, 1, 32'h44, 2'b00, 4'b0010, 4'b0001, 32'h44,  1, 0, 0, 11, 4, 2'b00);
      // aliasing: taken at 0x04 moves 0x44; 0x08 untouched
      vec(0, 1, 32'h04, 2'b00, 4'b1010, 4'b0010, 32'h44,  1, 1, 1, 12, 5, 2'b01);
      vec(0, 0, 32'h04, 2'b00, 4'b1010, 4'b0010, 32'h08,  0, 0, 0, 12, 5, 2'b01);
      // non-conditional ops and invalid conditional: no effect
      vec(0, 1, 32'h44, 2'b00, 4'b1111, 4'b0001, 32'h44,  0, 0, 0, 12, 5, 2'b01);
      vec(0, 1, 32'h40, 2'b00, 4'b0000, 4'b0001, 32'h40,  0, 0, 0, 12, 5, 2'b10);
      vec(0, 1, 32'h40, 2'b00, 4'b0101, 4'b0001, 32'h40,  0, 0, 0, 12, 5, 2'b10);
      vec(0, 0, 32'h40, 2'b00, 4'b1001, 4'b0001, 32'h40,  0, 0, 0, 12, 5, 2'b10);
      // remaining branch types, back to back at 0x48
      vec(0, 1, 32'h48, 2'b01, 4'b1100, 4'b0010, 32'h48,  1, 1, 1, 13, 6, 2'b10);
      vec(0, 1, 32'h48, 2'b10, 4'b1100, 4'b0001, 32'h48,  1, 0, 1, 14, 7, 2'b01);
      vec(0, 1, 32'h48, 2'b01, 4'b0001, 4'b0001, 32'h48,  1, 1, 1, 15, 8, 2'b10);
      vec(0, 1, 32'h48, 2'b10, 4'b0001, 4'b0011, 32'h48,  1, 0, 1, 16, 9, 2'b01);
      vec(0, 1, 32'h48, 2'b01, 4'b1011, 4'b0011, 32'h48,  1, 1, 1, 17, 10, 2'b10);
      // carried state says not-taken, table says taken: no mispredict, table trains down
      vec(0, 1, 32'h48, 2'b00, 4'b1001, 4'b0010, 32'h48,  1, 0, 0, 18, 10, 2'b01);
      // clear collides with a taken update
      vec(1, 1, 32'h40, 2'b10, 4'b1001, 4'b0001, 32'h40,  0, 0, 0, 0, 0, 2'b01);
      vec(0, 0, 32'h40, 2'b00, 4'b0000, 4'b0000, 32'h44,  0, 0, 0, 0, 0, 2'b01);
      vec(0, 0, 32'h40, 2'b00, 4'b0000, 4'b0000, 32'h48,  0, 0, 0, 0, 0, 2'b01);
      @(negedge clk);
      ex_valid = 1'b0; clr = 1'b0;
      budget = 0;
      while (sb.size() > 0 && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      if (sb.size() > 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_predict_table.md
# branch_predict_table

Parametrised bimodal branch predictor for the fetch/EXE pipeline, generalising the single-entry predict checker. Holds ENTRIES saturating counters indexed by PC, serves a combinational prediction to IF, resolves conditional branches in EXE from comparator flags, and raises a registered mispredict pulse. It also trains the table and keeps saturating branch/miss statistics.

## Interface
- ENTRIES, 16: number of counters; power of two, ≥2; IDX_W = log2(ENTRIES).
- PC_W, 32: PC width; must satisfy PC_W ≥ IDX_W+2.
- CTR_W, 2: counter width, ≥2; predict taken when MSB = 1.
- INIT_STATE, 2^(CTR_W-1)-1: reset/clear value of every counter (weak not-taken for CTR_W=2).
- STAT_W, 16: statistics counter width.
- BITS, 4: CMP_TYPE/CMP_FLAG width.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  reset; asynchronous, active-low.
- CLR  in  1  synchronous clear of table and statistics.
- IF_PC  in  PC_W  fetch PC.
- PRED_STATE  out  CTR_W  counter at index(IF_PC); travels down the pipe.
- PRED_TAKEN  out  1  MSB of PRED_STATE.
- EX_VALID  in  1  EXE holds a valid instruction.
- EX_PC  in  PC_W  EXE instruction PC.
- EX_PRED_STATE  in  CTR_W  PRED_STATE captured at fetch for this instruction.
- CMP_TYPE  in  BITS  branch type.
- CMP_FLAG  in  BITS  comparator result.
- IS_COND  out  1  registered: previous EXE op was a valid conditional branch.
- ACT_TAKEN  out  1  registered: its resolved direction.
- MISPREDICT  out  1  registered: its prediction was wrong.
- BR_CNT  out  STAT_W  conditional branches resolved.
- MISS_CNT  out  STAT_W  mispredicts.

## Operation
- index(pc) = pc[IDX_W+1:2].
- CMP_FLAG codes: EQ=0001, G=0010, L=0011.
- Conditional CMP_TYPE codes and resolved taken:
  - 1001 BEQ: flag==EQ.
  - 1010: flag==G.
  - 1011: flag==L.
  - 1100 BNE: flag==G or flag==L.
  - 0001 BGE: flag==EQ or flag==G.
  - 0010 BLTU: flag==L.
- Non-conditional CMP_TYPE:
  - 0000 normal and 1111 JAL are not conditional.
  - Any other code is also not conditional.
  - Non-conditional ops never train, count or mispredict.
- cond = EX_VALID and CMP_TYPE is conditional.
- taken = resolved direction per the table above.
- pred = MSB of EX_PRED_STATE. The carried state is used, not the current table value.
- Training, when cond:
  - ctr[index(EX_PC)] increments if taken, saturating at 2^CTR_W-1.
  - It decrements if not taken, saturating at 0.
  - Training starts from the current table value, not EX_PRED_STATE.
- Statistics, when cond:
  - BR_CNT += 1.
  - MISS_CNT += 1 if taken ≠ pred.
  - Both saturate at 2^STAT_W-1 and never wrap.
- CLR, priority over training: all counters go to INIT_STATE, BR_CNT/MISS_CNT go to 0, and IS_COND/ACT_TAKEN/MISPREDICT go to 0 next cycle.
- Reset: all counters = INIT_STATE; IS_COND, ACT_TAKEN, MISPREDICT, BR_CNT, MISS_CNT = 0. PRED_* then reflect INIT_STATE.

## Timing
- PRED_STATE/PRED_TAKEN: combinational from IF_PC and table, same cycle.
- IS_COND/ACT_TAKEN/MISPREDICT: registered; valid the cycle after EX inputs are sampled; single-cycle pulses. With back-to-back branches they update every cycle.
- Counter and statistics writes take effect at the sampling edge. A fetch read on the same index in the same cycle returns the old value (no bypass). The next cycle returns the new value.
- One update per cycle; IF read and EX update proceed concurrently with no stall.
- RST_N assertion mid-operation clears everything immediately, with no dependence on CLK.

## Test plan
- Reset, then IF_PC=0x40 → PRED_STATE=01, PRED_TAKEN=0; all outputs 0.
- EX_PC=0x40, BEQ, flag=EQ, EX_PRED_STATE=01, one cycle:
  - next cycle: IS_COND=1, ACT_TAKEN=1, MISPREDICT=1, BR_CNT=1, MISS_CNT=1;
  - IF_PC=0x40 then gives PRED_STATE=10.
- Saturation: four taken BLTU (flag=L) at 0x44 from reset → counter 11; fifth taken stays 11. Four not-taken → 00; further not-taken stays 00.
- Aliasing with ENTRIES=16: a taken branch at 0x04 also changes the prediction for 0x44. 0x08 is unchanged.
- JAL or type 0000 with EX_VALID=1 → IS_COND=0, MISPREDICT=0; table and stats unchanged. Same for any conditional type with EX_VALID=0.
- CLR asserted in the same cycle as a taken update → table all INIT_STATE and BR_CNT=0. With STAT_W=2, five branches → BR_CNT=3.
